// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, widths and address check for the data-memory responder
package dmem_pkg;

    localparam int CNT_W  = 4;
    localparam int BE_W   = 4;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Misaligned or beyond the last stored word; no wrap-around.
    function automatic logic addr_is_bad(input logic [31:0] addr, input int unsigned depth_words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth_words);
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// rtl/dmem_bank.sv - word storage with synchronous byte-lane write and synchronous read
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int          IDX_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic              clr_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [BE_W-1:0]   be_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be_i[i]) begin
                    mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Read register stays zero outside a read response so it can drive the response bus directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[idx_i];
        end else if (clr_i) begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data-memory target with valid/ready request and response channels
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [31:0]         addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic                err_q, err_d;

    logic                commit;
    logic                bank_wr;
    logic                bank_rd;
    logic                bank_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
        end
    end

    // The _d copies of the request feed the bank so a zero-wait commit sees the live request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                    end else begin
                        state_d = RESP;
                        err_d   = addr_is_bad(req_addr, DEPTH_WORDS);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    state_d = RESP;
                    err_d   = addr_is_bad(addr_q, DEPTH_WORDS);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        commit    = rst_n && (state_d == RESP) && (state_q != RESP);
        bank_wr   = commit && we_d && !err_d;
        bank_rd   = commit && !we_d && !err_d;
        bank_clr  = (state_q == RESP) && rsp_ready;
    end

    assign rsp_err = err_q;

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en_i (bank_wr),
        .rd_en_i (bank_rd),
        .clr_i   (bank_clr),
        .idx_i   (addr_d[IDX_W+1:2]),
        .wdata_i (wdata_d),
        .be_i    (be_d),
        .rdata_o (rsp_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int WAITC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_ready, z_req_we;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_be;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(4), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    rsp_t        exp_q[$];
    logic [31:0] ref_mem [DEPTH];
    bit          rand_rdy = 0;
    bit          hold_off = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rsp_t apply_ref(input logic we, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [3:0] be);
        rsp_t r;
        int unsigned w;
        w       = addr / 4;
        r.err   = (addr % 4 != 0) || (w >= DEPTH);
        r.rdata = 32'h0;
        if (!r.err) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[w][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                r.rdata = ref_mem[w];
            end
        end
        return r;
    endfunction

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input bit commit_it);
        int t;
        bit acc;
        t   = 0;
        acc = 0;
        if (commit_it) exp_q.push_back(apply_ref(we, addr, wdata, be));
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got no accept expected accept of addr %h", addr);
        end
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic z_txn(input string nm, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] exp_rd, input logic exp_err);
        z_req_valid = 1'b1;
        z_req_we    = we;
        z_req_addr  = addr;
        z_req_wdata = wdata;
        z_req_be    = be;
        @(posedge clk);
        #1;
        z_req_valid = 1'b0;
        check({nm, "_valid"}, z_rsp_valid, 1);
        check({nm, "_rdata"}, z_rsp_rdata, exp_rd);
        check({nm, "_err"}, z_rsp_err, exp_err);
        @(posedge clk);
        #1;
        check({nm, "_done"}, z_rsp_valid, 0);
    endtask

    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = hold_off ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    bit          busy  = 0;
    bit          stall = 0;
    bit          track = 0;
    int          lat   = 0;
    logic [31:0] sv_rdata;
    logic        sv_err;
    rsp_t        got;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy  = 0;
            stall = 0;
            track = 0;
        end else begin
            check("req_ready", req_ready, !busy);
            if (track) begin
                lat++;
                if (rsp_valid) begin
                    check("latency", lat, WAITC + 1);
                    track = 0;
                end
            end
            if (!rsp_valid) begin
                check("idle_rdata", rsp_rdata, 0);
                check("idle_err", rsp_err, 0);
            end else begin
                check("valid_while_busy", busy, 1);
                if (stall) begin
                    check("stall_rdata", rsp_rdata, sv_rdata);
                    check("stall_err", rsp_err, sv_err);
                end
                if (rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_rsp: got rdata %h err %b expected none", rsp_rdata, rsp_err);
                    end else begin
                        got = exp_q.pop_front();
                        check("rsp_rdata", rsp_rdata, got.rdata);
                        check("rsp_err", rsp_err, got.err);
                    end
                    busy  = 0;
                    stall = 0;
                end else begin
                    stall    = 1;
                    sv_rdata = rsp_rdata;
                    sv_err   = rsp_err;
                end
            end
            if (req_valid && req_ready) begin
                busy  = 1;
                track = 1;
                lat   = 0;
            end
        end
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int r;
        logic [31:0] a;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_be      = '0;
        z_req_valid = 1'b0;
        z_req_we    = 1'b0;
        z_req_addr  = '0;
        z_req_wdata = '0;
        z_req_be    = '0;
        z_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);

        rand_rdy = 1;
        for (int w = 0; w < DEPTH; w++) do_req(1'b1, 32'(w * 4), $urandom, 4'hF, 1);
        wait_idle();

        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 1);
        do_req(1'b1, 32'h10, 32'h11223344, 4'b0101, 1);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 1);
        wait_idle();
        check("partial_model", ref_mem[4], 32'hDE22BE44);

        do_req(1'b0, 32'h13, 32'h0, 4'h0, 1);
        do_req(1'b1, 32'(DEPTH * 4), 32'hA5A5A5A5, 4'hF, 1);
        for (int w = 0; w < DEPTH; w++) do_req(1'b0, 32'(w * 4), 32'h0, 4'h0, 1);
        wait_idle();

        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = {22'h0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
            else if (r == 7) a = 32'($urandom_range(0, 1023));
            else if (r == 8) a = 32'(DEPTH * 4 + $urandom_range(0, 4095) * 4);
            else             a = $urandom;
            do_req(1'($urandom), a, $urandom, 4'($urandom), 1);
        end
        wait_idle();

        rand_rdy = 0;
        hold_off = 1;
        @(posedge clk);
        #1;
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 1);
        t = 0;
        while (!rsp_valid && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("bp_rsp_seen", rsp_valid, 1);
        fork
            begin
                repeat (5) @(posedge clk);
                #1;
                hold_off = 0;
            end
            do_req(1'b1, 32'h44, 32'h0BADF00D, 4'hF, 1);
        join
        wait_idle();
        do_req(1'b0, 32'h44, 32'h0, 4'h0, 1);
        wait_idle();

        do_req(1'b1, 32'h20, 32'h5A5AA5A5, 4'hF, 0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_rsp_valid", rsp_valid, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", req_ready, 1);
        check("post_rst_rdata", rsp_rdata, 0);
        do_req(1'b0, 32'h20, 32'h0, 4'h0, 1);
        wait_idle();

        z_txn("z_wr", 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
        z_txn("z_rd", 1'b0, 32'h8, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
        z_txn("z_oob", 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b1);
        z_txn("z_be0", 1'b1, 32'h8, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
        z_txn("z_rd2", 1'b0, 32'h8, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
        z_txn("z_mis", 1'b1, 32'h2, 32'h12345678, 4'hF, 32'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
